mux4_scan_ctrl: RTL and testbench
=================================

MUX4_SCAN_CTRL -- requirements
Module: mux4_scan_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, is the number of clocks sel_out is held stable before y_in is sampled; legal range 1..15.
REQ-002 clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_in  input  1  reset; synchronous, active-high.
REQ-004 start_in  input  1  request a conversion; sampled only in IDLE.
REQ-005 mode_in  input  1  0 = scan channels 0..3; 1 = single channel chan_in; sampled with start_in.
REQ-006 chan_in  input  2  channel for single mode; sampled with start_in.
REQ-007 y_in  input  1  mux output (y_out of the 4:1 mux this block drives).
REQ-008 sel_out  output  2  select driven to the mux sel_in, registered.
REQ-009 data_out  output  4  captured word; bit n = y_in sampled while sel_out = n.
REQ-010 valid_out  output  1  one-cycle pulse: data_out updated.
REQ-011 busy_out  output  1  high whenever state is not IDLE.
REQ-012 overrun_out  output  1  sticky flag: start_in seen while busy.

Function
REQ-013 FSM has states IDLE, SETTLE, SAMPLE and DONE, with a 4-bit settle counter.
REQ-014 IDLE with start_in=1: latch mode_in/chan_in; load sel_out = 0 (scan) or chan_in (single); load counter = SETTLE_CYCLES; copy data_out into shadow register; clear overrun_out; go to SETTLE.
REQ-015 SETTLE lasts exactly SETTLE_CYCLES clocks, decrementing the counter, then goes to SAMPLE; y_in is ignored throughout.
REQ-016 SAMPLE lasts one clock and writes y_in into shadow bit[sel_out] at its closing edge.
REQ-017 SAMPLE in scan mode with sel_out < 3: sel_out increments, counter reloads, go to SETTLE.
REQ-018 SAMPLE in scan mode with sel_out = 3, or in single mode: go to DONE; sel_out holds its value.
REQ-019 DONE lasts one clock: data_out = shadow and valid_out = 1 during that cycle, then go to IDLE.
REQ-020 Latency from the accept edge to the valid_out cycle, with S = SETTLE_CYCLES: scan = 4*(S+1)+1 clocks; single = S+2 clocks.
REQ-021 Single mode changes only bit[chan] of data_out; the other three bits keep their previous values.
REQ-022 data_out changes only in DONE and holds its value between conversions.
REQ-023 sel_out changes only on the accept edge or on a SAMPLE edge, and never inside SETTLE.
REQ-024 start_in=1 in SETTLE, SAMPLE or DONE is ignored (no restart, no abort) and sets overrun_out, which stays set until the next accepted start.
REQ-025 start_in held high continuously: one conversion is accepted per IDLE visit, back-to-back, and overrun_out sets.
REQ-026 sel_out does not wrap in scan mode: 3 is the terminal channel.

Reset
REQ-027 rst_in=1 at a clock edge forces IDLE; sel_out, data_out, the shadow register, the counter, valid_out, busy_out and overrun_out all become 0 from any state.
REQ-028 rst_in has priority over start_in in the same cycle; no conversion is accepted.
REQ-029 Reset mid-conversion discards the partial shadow register; no valid_out pulse follows.

Verification
REQ-030 Reset: assert rst_in for 2 cycles -> all outputs 0 and busy_out=0 on the next edge.
REQ-031 Scan with S=2, mux data=4'b0101: pulse start_in with mode_in=0 -> sel_out sequence 0,1,2,3 (3 cycles each); valid_out high exactly 13 cycles after accept; data_out=4'b0101.
REQ-032 Single with S=2, prior data_out=4'b1010, mux data=4'b0100: mode_in=1, chan_in=2 -> sel_out=2; valid_out 4 cycles after accept; data_out=4'b1110.
REQ-033 Overrun: pulse start_in again 3 cycles into a scan -> scan completes unaltered and overrun_out=1; next accepted start clears it.
REQ-034 Settle window: mux data toggles during SETTLE and is stable in SAMPLE -> data_out reflects the SAMPLE-cycle values only.
REQ-035 Reset mid-scan: rst_in at cycle 6 of a scan -> next edge shows state IDLE and all outputs 0, no valid_out; a fresh start then completes normally.

Source files
------------

// File: rtl/mux4_scan_ctrl.sv
// Sequencer for an external 4:1 mux: steps the select, waits for the mux output
// to settle, samples y_in per channel and publishes the captured 4-bit word.
module mux4_scan_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       start_in,
    input  logic       mode_in,
    input  logic [1:0] chan_in,
    input  logic       y_in,
    output logic [1:0] sel_out,
    output logic [3:0] data_out,
    output logic       valid_out,
    output logic       busy_out,
    output logic       overrun_out
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [1:0] sel_nxt;
    logic [3:0] shadow, shadow_nxt;
    logic [3:0] data_nxt;
    logic       mode_q, mode_nxt;
    logic       valid_nxt;
    logic       overrun_nxt;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            sel_out     <= 2'd0;
            shadow      <= 4'd0;
            data_out    <= 4'd0;
            mode_q      <= 1'b0;
            valid_out   <= 1'b0;
            overrun_out <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            sel_out     <= sel_nxt;
            shadow      <= shadow_nxt;
            data_out    <= data_nxt;
            mode_q      <= mode_nxt;
            valid_out   <= valid_nxt;
            overrun_out <= overrun_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        sel_nxt     = sel_out;
        shadow_nxt  = shadow;
        data_nxt    = data_out;
        mode_nxt    = mode_q;
        valid_nxt   = 1'b0;
        overrun_nxt = overrun_out;

        // A start request while a conversion is in flight is only recorded.
        if (start_in && (state != IDLE)) begin
            overrun_nxt = 1'b1;
        end

        case (state)
            IDLE: begin
                if (start_in) begin
                    mode_nxt    = mode_in;
                    sel_nxt     = mode_in ? chan_in : 2'd0;
                    cnt_nxt     = SETTLE_LOAD;
                    // Seeding from data_out lets single mode touch one bit only.
                    shadow_nxt  = data_out;
                    overrun_nxt = 1'b0;
                    state_nxt   = SETTLE;
                end
            end
            SETTLE: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                shadow_nxt[sel_out] = y_in;
                if (!mode_q && (sel_out != 2'd3)) begin
                    sel_nxt   = sel_out + 2'd1;
                    cnt_nxt   = SETTLE_LOAD;
                    state_nxt = SETTLE;
                end else begin
                    data_nxt  = shadow_nxt;
                    valid_nxt = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy_out = (state != IDLE);

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Self-checking bench for mux4_scan_ctrl: cycle-indexed expectations derived from
// the settle/sample timing rules, with a mux model driving y_in from sel_out.
module tb_mux4_scan_ctrl;

    localparam int S = 2;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b0;
    logic       start_in = 1'b0;
    logic       mode_in = 1'b0;
    logic [1:0] chan_in = 2'd0;
    logic       y_in;
    logic [1:0] sel_out;
    logic [3:0] data_out;
    logic       valid_out;
    logic       busy_out;
    logic       overrun_out;

    logic [3:0] mux_data = 4'd0;
    logic       noise_en = 1'b0;
    logic       noise_bit = 1'b0;

    assign y_in = noise_en ? noise_bit : mux_data[sel_out];

    always #5 clk_in = ~clk_in;

    mux4_scan_ctrl #(.SETTLE_CYCLES(S)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .start_in    (start_in),
        .mode_in     (mode_in),
        .chan_in     (chan_in),
        .y_in        (y_in),
        .sel_out     (sel_out),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .busy_out    (busy_out),
        .overrun_out (overrun_out)
    );

    int checks = 0;
    int errors = 0;
    bit [3:0] model_data = 4'd0;

    logic [1:0] obs_sel   [64];
    logic [3:0] obs_data  [64];
    logic       obs_valid [64];
    logic       obs_busy  [64];
    logic       obs_ovr   [64];

    function automatic int latency(bit mode);
        return mode ? S + 2 : 4 * (S + 1) + 1;
    endfunction

    function automatic bit is_sample(bit mode, int k);
        if (mode) return k == S + 1;
        return (k % (S + 1) == 0) && (k >= S + 1) && (k <= 4 * (S + 1));
    endfunction

    function automatic logic [1:0] exp_sel(bit mode, bit [1:0] ch, int k);
        int q;
        if (mode) return ch;
        q = (k - 1) / (S + 1);
        if (q > 3) q = 3;
        return 2'(q);
    endfunction

    function automatic bit [3:0] model_result(bit mode, bit [1:0] ch, bit [3:0] mux, bit [3:0] prev);
        bit [3:0] r;
        if (!mode) return mux;
        r = prev;
        r[ch] = mux[ch];
        return r;
    endfunction

    // Issues one start and records outputs for cycles 1..ncyc after the accept edge.
    task automatic run_conv(input bit mode, input bit [1:0] ch, input bit [3:0] mux,
                            input bit noisy, input int restart_at, input int rst_at, input int ncyc);
        mux_data = mux;
        mode_in  = mode;
        chan_in  = ch;
        start_in = 1'b1;
        noise_en = 1'b0;
        @(posedge clk_in); #1;
        for (int k = 1; k <= ncyc; k++) begin
            obs_sel[k]   = sel_out;
            obs_data[k]  = data_out;
            obs_valid[k] = valid_out;
            obs_busy[k]  = busy_out;
            obs_ovr[k]   = overrun_out;
            start_in  = (k == restart_at);
            rst_in    = (k == rst_at);
            noise_en  = noisy && !is_sample(mode, k);
            noise_bit = 1'($urandom);
            @(posedge clk_in); #1;
        end
        start_in = 1'b0;
        rst_in   = 1'b0;
        noise_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_in   = 1'b1;
        start_in = 1'b1;
        mode_in  = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        checks++;
        if ({sel_out, data_out, valid_out, busy_out, overrun_out} !== 9'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b required 0", {sel_out, data_out, valid_out, busy_out, overrun_out});
        end
        rst_in   = 1'b0;
        start_in = 1'b0;
        @(posedge clk_in); #1;
        checks++;
        if (busy_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_priority busy got %b required 0", busy_out);
        end
        model_data = 4'd0;
    endtask

    task automatic test_scan();
        int lat = latency(1'b0);
        for (int t = 0; t < 4; t++) begin
            bit [3:0] mux = (t == 0) ? 4'b0101 : 4'($urandom);
            bit [3:0] expd = model_result(1'b0, 2'd0, mux, model_data);
            run_conv(1'b0, 2'd0, mux, 1'b0, 0, 0, lat + 2);
            for (int k = 1; k <= lat + 2; k++) begin
                checks++;
                if (obs_sel[k] !== exp_sel(1'b0, 2'd0, k)) begin
                    errors++;
                    $display("FAIL scan_sel k=%0d got %0d required %0d", k, obs_sel[k], exp_sel(1'b0, 2'd0, k));
                end
                checks++;
                if (obs_valid[k] !== (k == lat) || obs_busy[k] !== (k <= lat)) begin
                    errors++;
                    $display("FAIL scan_valid_busy k=%0d got %b%b required %b%b", k, obs_valid[k], obs_busy[k], k == lat, k <= lat);
                end
                checks++;
                if (obs_data[k] !== ((k >= lat) ? expd : model_data)) begin
                    errors++;
                    $display("FAIL scan_data k=%0d got %b required %b", k, obs_data[k], (k >= lat) ? expd : model_data);
                end
            end
            model_data = expd;
        end
    endtask

    task automatic test_single();
        int lat = latency(1'b1);
        run_conv(1'b0, 2'd0, 4'b1010, 1'b0, 0, 0, latency(1'b0) + 1);
        model_data = 4'b1010;
        for (int t = 0; t < 5; t++) begin
            bit [1:0] ch  = (t == 0) ? 2'd2 : 2'($urandom);
            bit [3:0] mux = (t == 0) ? 4'b0100 : 4'($urandom);
            bit [3:0] expd = model_result(1'b1, ch, mux, model_data);
            run_conv(1'b1, ch, mux, 1'b0, 0, 0, lat + 2);
            for (int k = 1; k <= lat + 2; k++) begin
                checks++;
                if (obs_sel[k] !== ch) begin
                    errors++;
                    $display("FAIL single_sel k=%0d got %0d required %0d", k, obs_sel[k], ch);
                end
                checks++;
                if (obs_valid[k] !== (k == lat) || obs_busy[k] !== (k <= lat)) begin
                    errors++;
                    $display("FAIL single_valid_busy k=%0d got %b%b required %b%b", k, obs_valid[k], obs_busy[k], k == lat, k <= lat);
                end
                checks++;
                if (obs_data[k] !== ((k >= lat) ? expd : model_data)) begin
                    errors++;
                    $display("FAIL single_data k=%0d got %b required %b", k, obs_data[k], (k >= lat) ? expd : model_data);
                end
            end
            model_data = expd;
        end
    endtask

    task automatic test_overrun();
        int lat = latency(1'b0);
        bit [3:0] mux = 4'($urandom);
        run_conv(1'b0, 2'd0, mux, 1'b0, 3, 0, lat + 2);
        for (int k = 1; k <= lat + 2; k++) begin
            checks++;
            if (obs_ovr[k] !== (k > 3)) begin
                errors++;
                $display("FAIL overrun_set k=%0d got %b required %b", k, obs_ovr[k], k > 3);
            end
            checks++;
            if (obs_valid[k] !== (k == lat) || obs_sel[k] !== exp_sel(1'b0, 2'd0, k)) begin
                errors++;
                $display("FAIL overrun_scan k=%0d got v%b s%0d required v%b s%0d", k, obs_valid[k], obs_sel[k], k == lat, exp_sel(1'b0, 2'd0, k));
            end
        end
        checks++;
        if (obs_data[lat] !== mux) begin
            errors++;
            $display("FAIL overrun_data got %b required %b", obs_data[lat], mux);
        end
        model_data = mux;
        run_conv(1'b1, 2'd1, 4'($urandom), 1'b0, 0, 0, latency(1'b1));
        model_data = model_result(1'b1, 2'd1, mux_data, model_data);
        for (int k = 1; k <= latency(1'b1); k++) begin
            checks++;
            if (obs_ovr[k] !== 1'b0) begin
                errors++;
                $display("FAIL overrun_clear k=%0d got %b required 0", k, obs_ovr[k]);
            end
        end
    endtask

    task automatic test_settle_window();
        for (int t = 0; t < 4; t++) begin
            bit mode = (t == 3);
            bit [1:0] ch = 2'($urandom);
            bit [3:0] mux = 4'($urandom);
            bit [3:0] expd = model_result(mode, ch, mux, model_data);
            int lat = latency(mode);
            run_conv(mode, ch, mux, 1'b1, 0, 0, lat + 1);
            checks++;
            if (obs_valid[lat] !== 1'b1 || obs_data[lat] !== expd) begin
                errors++;
                $display("FAIL settle_data t=%0d got v%b %b required v1 %b", t, obs_valid[lat], obs_data[lat], expd);
            end
            model_data = expd;
        end
    endtask

    task automatic test_reset_mid();
        int lat = latency(1'b0);
        bit [3:0] mux = 4'($urandom);
        run_conv(1'b0, 2'd0, mux, 1'b0, 0, 6, lat + 2);
        for (int k = 7; k <= lat + 2; k++) begin
            checks++;
            if ({obs_sel[k], obs_data[k], obs_valid[k], obs_busy[k], obs_ovr[k]} !== 9'd0) begin
                errors++;
                $display("FAIL reset_mid k=%0d got %b required 0", k,
                         {obs_sel[k], obs_data[k], obs_valid[k], obs_busy[k], obs_ovr[k]});
            end
        end
        model_data = 4'd0;
        mux = 4'($urandom);
        run_conv(1'b0, 2'd0, mux, 1'b0, 0, 0, lat + 1);
        checks++;
        if (obs_valid[lat] !== 1'b1 || obs_data[lat] !== mux) begin
            errors++;
            $display("FAIL reset_mid_fresh got v%b %b required v1 %b", obs_valid[lat], obs_data[lat], mux);
        end
        model_data = mux;
    endtask

    task automatic test_back_to_back();
        int lat = latency(1'b0);
        bit [3:0] mux1 = 4'($urandom);
        bit [3:0] mux2 = 4'($urandom);
        mux_data = mux1;
        mode_in  = 1'b0;
        start_in = 1'b1;
        @(posedge clk_in); #1;
        for (int k = 1; k <= 2 * lat + 1; k++) begin
            bit exp_v = (k == lat) || (k == 2 * lat + 1);
            bit exp_o = (k >= 2) && (k != lat + 2);
            checks++;
            if (valid_out !== exp_v || overrun_out !== exp_o) begin
                errors++;
                $display("FAIL b2b_valid_ovr k=%0d got %b%b required %b%b", k, valid_out, overrun_out, exp_v, exp_o);
            end
            if (k == lat) begin
                checks++;
                if (data_out !== mux1) begin
                    errors++;
                    $display("FAIL b2b_data1 got %b required %b", data_out, mux1);
                end
                mux_data = mux2;
            end
            if (k == 2 * lat + 1) begin
                checks++;
                if (data_out !== mux2) begin
                    errors++;
                    $display("FAIL b2b_data2 got %b required %b", data_out, mux2);
                end
                start_in = 1'b0;
            end
            @(posedge clk_in); #1;
        end
        @(posedge clk_in); #1;
        checks++;
        if (busy_out !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle busy got %b required 0", busy_out);
        end
        model_data = mux2;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_single();
        test_overrun();
        test_settle_window();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
